instr_encoder: RTL and testbench

Sequential RV32I instruction encoder and program loader: accepts per-instruction field bundles over a valid/ready stream, packs them into 32-bit instruction words in the same bit layout the core's instruction decoder unpacks, and writes them to consecutive instruction-memory addresses. Sits between the test/boot loader and the instruction memory write port. Bit positions are identical on both sides, so decoder and encoder round-trip.

---
 rtl/riscv_pkg.sv | 32 +++
 rtl/instr_pack.sv | 30 +++
 rtl/instr_encoder.sv | 141 ++++++++++++++
 tb/tb_instr_encoder.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I encoding definitions used by the instruction encoder and the decoder.
package riscv_pkg;

    typedef enum logic [2:0] {
        FMT_R = 3'd0,
        FMT_I = 3'd1,
        FMT_S = 3'd2,
        FMT_B = 3'd3,
        FMT_U = 3'd4,
        FMT_J = 3'd5
    } fmt_e;

    localparam logic [31:0] NOP    = 32'h0000_0013;

    localparam logic [6:0]  OP_IMM = 7'h13;
    localparam logic [6:0]  OP     = 7'h33;
    localparam logic [6:0]  STORE  = 7'h23;
    localparam logic [6:0]  BRANCH = 7'h63;
    localparam logic [6:0]  LUI    = 7'h37;
    localparam logic [6:0]  JAL    = 7'h6F;

    typedef struct packed {
        logic [6:0]  funct7;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [2:0]  funct3;
        logic [4:0]  rd;
        logic [6:0]  opcode;
        logic [31:0] imm;
    } instr_fields_t;

endpackage

// File: rtl/instr_pack.sv
// Combinational RV32I field packer: fields + format -> 32-bit instruction word.
module instr_pack
    import riscv_pkg::*;
(
    input  logic [2:0]    fmt,
    input  instr_fields_t fields,
    output logic [31:0]   word,
    output logic          illegal
);

    always_comb begin
        word    = NOP;
        illegal = 1'b0;
        case (fmt)
            FMT_R: word = {fields.funct7, fields.rs2, fields.rs1, fields.funct3,
                           fields.rd, fields.opcode};
            FMT_I: word = {fields.imm[11:0], fields.rs1, fields.funct3, fields.rd,
                           fields.opcode};
            FMT_S: word = {fields.imm[11:5], fields.rs2, fields.rs1, fields.funct3,
                           fields.imm[4:0], fields.opcode};
            FMT_B: word = {fields.imm[12], fields.imm[10:5], fields.rs2, fields.rs1,
                           fields.funct3, fields.imm[4:1], fields.imm[11], fields.opcode};
            FMT_U: word = {fields.imm[31:12], fields.rd, fields.opcode};
            FMT_J: word = {fields.imm[20], fields.imm[10:1], fields.imm[11],
                           fields.imm[19:12], fields.rd, fields.opcode};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams field bundles into encoded RV32I words written to consecutive
// instruction-memory addresses, one registered write per accepted beat.
module instr_encoder
    import riscv_pkg::*;
#(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        fmt,
    input  logic [6:0]        opcode,
    input  logic [6:0]        funct7,
    input  logic [2:0]        funct3,
    input  logic [4:0]        rs1,
    input  logic [4:0]        rs2,
    input  logic [4:0]        rd,
    input  logic [31:0]       imm,
    input  logic              last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam int unsigned CAP_INT = (1 << ADDR_W) - BASE_ADDR;
    localparam logic [ADDR_W:0]   CAPACITY = (ADDR_W + 1)'(CAP_INT);
    localparam logic [ADDR_W-1:0] BASE     = ADDR_W'(BASE_ADDR);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [ADDR_W:0]   count_q, count_d;
    logic              err_q, err_d;
    logic              last_seen_q, last_seen_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    instr_fields_t     fields;
    logic [31:0]       word;
    logic              illegal;
    logic              accept;

    assign fields = '{funct7: funct7, rs2: rs2, rs1: rs1, funct3: funct3,
                      rd: rd, opcode: opcode, imm: imm};

    instr_pack u_pack (
        .fmt     (fmt),
        .fields  (fields),
        .word    (word),
        .illegal (illegal)
    );

    assign in_ready  = (state_q == S_LOAD) && !last_seen_q;
    assign accept    = in_valid && in_ready;
    assign busy      = (state_q == S_LOAD);
    assign done      = (state_q == S_DONE);
    assign err       = err_q;
    assign count     = count_q;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = wdata_q;

    always_comb begin
        state_d     = state_q;
        ptr_d       = ptr_q;
        count_d     = count_q;
        err_d       = err_q;
        last_seen_d = last_seen_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d     = S_LOAD;
                    ptr_d       = BASE;
                    count_d     = '0;
                    err_d       = 1'b0;
                    last_seen_d = 1'b0;
                end
            end
            S_LOAD: begin
                if (last_seen_q) begin
                    state_d = S_DONE;
                end else if (accept) begin
                    last_seen_d = last;
                    // A full memory drops the beat; the count guard also keeps
                    // the pointer from ever producing a wrapped address.
                    if (count_q == CAPACITY) begin
                        err_d = 1'b1;
                    end else begin
                        we_d    = 1'b1;
                        addr_d  = ptr_q;
                        wdata_d = word;
                        ptr_d   = ptr_q + 1'b1;
                        count_d = count_q + 1'b1;
                        if (illegal) err_d = 1'b1;
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            ptr_q       <= '0;
            count_q     <= '0;
            err_q       <= 1'b0;
            last_seen_q <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            wdata_q     <= '0;
        end else begin
            state_q     <= state_d;
            ptr_q       <= ptr_d;
            count_q     <= count_d;
            err_q       <= err_d;
            last_seen_q <= last_seen_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: a default instance for encoding/session
// behaviour and a tiny-memory instance for overflow and mid-session reset.
module tb_instr_encoder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Shared bundle fields
    logic [2:0]  fmt;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] imm;
    logic        last;

    // Instance A: ADDR_W=8, BASE_ADDR=0
    logic        a_rst_n, a_start, a_valid, a_in_ready, a_mem_we, a_busy, a_done, a_err;
    logic [7:0]  a_mem_addr;
    logic [31:0] a_mem_wdata;
    logic [8:0]  a_count;

    // Instance B: ADDR_W=2, BASE_ADDR=2
    logic        b_rst_n, b_start, b_valid, b_in_ready, b_mem_we, b_busy, b_done, b_err;
    logic [1:0]  b_mem_addr;
    logic [31:0] b_mem_wdata;
    logic [2:0]  b_count;

    instr_encoder #(.ADDR_W(8), .BASE_ADDR(0)) dut_a (
        .clk(clk), .rst_n(a_rst_n), .start(a_start), .in_valid(a_valid),
        .in_ready(a_in_ready), .fmt(fmt), .opcode(opcode), .funct7(funct7),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .last(last),
        .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
        .busy(a_busy), .done(a_done), .err(a_err), .count(a_count)
    );

    instr_encoder #(.ADDR_W(2), .BASE_ADDR(2)) dut_b (
        .clk(clk), .rst_n(b_rst_n), .start(b_start), .in_valid(b_valid),
        .in_ready(b_in_ready), .fmt(fmt), .opcode(opcode), .funct7(funct7),
        .funct3(funct3), .rs1(rs1), .rs2(rs2), .rd(rd), .imm(imm), .last(last),
        .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
        .busy(b_busy), .done(b_done), .err(b_err), .count(b_count)
    );

    typedef struct {
        logic [2:0]  fmt;
        logic [6:0]  op;
        logic [6:0]  f7;
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [31:0] imm;
        logic [31:0] word;
        logic        err;
    } vec_t;

    localparam int NV = 8;
    vec_t vecs[NV];
    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        fmt    = v.fmt;
        opcode = v.op;
        funct7 = v.f7;
        funct3 = v.f3;
        rs1    = v.rs1;
        rs2    = v.rs2;
        rd     = v.rd;
        imm    = v.imm;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        //          fmt   op     f7     f3    rs1 rs2 rd  imm            word           err
        vecs[0] = '{3'd1, 7'h13, 7'h00, 3'd0, 0,  0,  1,  32'h0000_0005, 32'h0050_0093, 1'b0};
        vecs[1] = '{3'd0, 7'h33, 7'h00, 3'd0, 1,  2,  3,  32'h0000_0000, 32'h0020_81B3, 1'b0};
        vecs[2] = '{3'd2, 7'h23, 7'h00, 3'd2, 1,  2,  0,  32'h0000_0008, 32'h0020_A423, 1'b0};
        vecs[3] = '{3'd3, 7'h63, 7'h00, 3'd0, 1,  2,  0,  32'hFFFF_FFFC, 32'hFE20_8EE3, 1'b0};
        vecs[4] = '{3'd4, 7'h37, 7'h00, 3'd0, 0,  0,  5,  32'h1234_5000, 32'h1234_52B7, 1'b0};
        vecs[5] = '{3'd5, 7'h6F, 7'h00, 3'd0, 0,  0,  1,  32'h0000_0008, 32'h0080_00EF, 1'b0};
        vecs[6] = '{3'd7, 7'h33, 7'h00, 3'd0, 1,  2,  1,  32'h0000_0000, 32'h0000_0013, 1'b1};
        vecs[7] = '{3'd0, 7'h33, 7'h20, 3'd0, 5,  6,  7,  32'h0000_0000, 32'h4062_83B3, 1'b1};

        a_rst_n = 1'b0; a_start = 1'b0; a_valid = 1'b0;
        b_rst_n = 1'b0; b_start = 1'b0; b_valid = 1'b0;
        last = 1'b0;
        drive(vecs[0]);
        repeat (2) tick();

        chk("rst in_ready", a_in_ready, 0);
        chk("rst mem_we", a_mem_we, 0);
        chk("rst mem_addr", a_mem_addr, 0);
        chk("rst mem_wdata", a_mem_wdata, 0);
        chk("rst busy", a_busy, 0);
        chk("rst done", a_done, 0);
        chk("rst err", a_err, 0);
        chk("rst count", a_count, 0);

        // Session 1: all formats back-to-back; start held high to show it is ignored.
        a_rst_n = 1'b1; b_rst_n = 1'b1;
        a_start = 1'b1;
        tick();
        chk("load busy", a_busy, 1);
        chk("load in_ready", a_in_ready, 1);
        chk("load count", a_count, 0);
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i]);
            a_valid = 1'b1;
            last    = (i == NV - 1);
            a_start = (i != NV - 1);
            tick();
            chk($sformatf("v%0d mem_we", i), a_mem_we, 1);
            chk($sformatf("v%0d mem_addr", i), a_mem_addr, i);
            chk($sformatf("v%0d mem_wdata", i), a_mem_wdata, vecs[i].word);
            chk($sformatf("v%0d count", i), a_count, i + 1);
            chk($sformatf("v%0d err", i), a_err, vecs[i].err);
        end
        a_valid = 1'b0; last = 1'b0; a_start = 1'b0;
        chk("after last in_ready", a_in_ready, 0);
        chk("after last busy", a_busy, 1);
        tick();
        chk("done pulse", a_done, 1);
        chk("done busy", a_busy, 0);
        chk("done mem_we", a_mem_we, 0);
        chk("done count", a_count, NV);
        chk("done err", a_err, 1);
        tick();
        chk("idle done", a_done, 0);
        chk("idle err held", a_err, 1);
        chk("idle in_ready", a_in_ready, 0);

        // Session 2: err and count clear on start, pointer restarts at base.
        a_start = 1'b1;
        tick();
        a_start = 1'b0;
        chk("s2 err cleared", a_err, 0);
        chk("s2 count", a_count, 0);
        drive(vecs[0]);
        a_valid = 1'b1; last = 1'b1;
        tick();
        a_valid = 1'b0; last = 1'b0;
        chk("s2 mem_we", a_mem_we, 1);
        chk("s2 mem_addr", a_mem_addr, 0);
        chk("s2 mem_wdata", a_mem_wdata, 32'h0050_0093);
        chk("s2 count", a_count, 1);
        tick();
        chk("s2 done", a_done, 1);
        chk("s2 err", a_err, 0);
        tick();

        // Instance B: capacity 2, third beat dropped.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(vecs[0]);
            b_valid = 1'b1;
            last    = (k == 2);
            tick();
            chk($sformatf("cap%0d mem_we", k), b_mem_we, (k < 2) ? 1 : 0);
            if (k < 2) chk($sformatf("cap%0d mem_addr", k), b_mem_addr, 2 + k);
            chk($sformatf("cap%0d count", k), b_count, (k < 2) ? k + 1 : 2);
            chk($sformatf("cap%0d err", k), b_err, (k == 2) ? 1 : 0);
        end
        b_valid = 1'b0; last = 1'b0;
        tick();
        chk("cap done", b_done, 1);
        chk("cap err", b_err, 1);
        chk("cap count", b_count, 2);
        tick();

        // Instance B: reset while a beat is being presented mid-session.
        b_start = 1'b1;
        tick();
        b_start = 1'b0;
        drive(vecs[1]);
        b_valid = 1'b1;
        tick();
        chk("mid first mem_we", b_mem_we, 1);
        chk("mid first mem_addr", b_mem_addr, 2);
        drive(vecs[2]);
        b_rst_n = 1'b0;
        tick();
        chk("mid rst mem_we", b_mem_we, 0);
        chk("mid rst mem_addr", b_mem_addr, 0);
        chk("mid rst mem_wdata", b_mem_wdata, 0);
        chk("mid rst in_ready", b_in_ready, 0);
        chk("mid rst busy", b_busy, 0);
        chk("mid rst done", b_done, 0);
        chk("mid rst err", b_err, 0);
        chk("mid rst count", b_count, 0);
        b_rst_n = 1'b1;
        b_valid = 1'b0;
        tick();
        chk("post rst busy", b_busy, 0);
        chk("post rst mem_we", b_mem_we, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
